// File: rtl/keypad_digit_accum.sv
// keypad_digit_accum: debounces the decoded key stream (0 = no key, 1..9 = digit)
// and shifts each accepted digit into a calculator-style BCD entry register.
// Optional build macro HOLD_REPEAT_EN: auto-repeat of a held key every RPT_CYC cycles.
//
// state | meaning
// IDLE  | no key held, waiting for a nonzero code
// DEB   | candidate code latched, counting stable samples
// HELD  | digit accepted, waiting for key release

module keypad_digit_accum #(
    parameter int NDIG    = 4,
    parameter int DEB_CYC = 4,
    parameter int RPT_CYC = 50
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [3:0]                     i,
    input  logic                           clr,
    input  logic                           bksp,
    output logic [4*NDIG-1:0]              o_bcd,
    output logic [$clog2(NDIG+1)-1:0]      o_cnt,
    output logic                           o_full,
    output logic                           o_stb,
    output logic                           o_err
);

    localparam int CW = $clog2(NDIG+1);
    localparam int DW = $clog2(DEB_CYC+1);

    typedef enum logic [1:0] {IDLE, DEB, HELD} state_t;

    state_t            state, state_nxt;
    logic [DW-1:0]     deb_cnt, deb_nxt;
    logic [3:0]        code, code_nxt;
    logic [3:0]        acc_code;
    logic              accept;
    logic              illegal;
    logic              bksp_q;
    logic              bksp_edge;
    logic [4*NDIG-1:0] bcd_shl;

`ifdef HOLD_REPEAT_EN
    localparam int RW = $clog2(RPT_CYC+1);
    logic [RW-1:0]     rpt_cnt, rpt_nxt;
    logic [3:0]        i_prev;
`endif

    assign o_full    = (o_cnt == CW'(NDIG));
    assign bksp_edge = bksp & ~bksp_q;

    // New digit enters the least significant nibble.
    if (NDIG > 1) begin : g_multi
        assign bcd_shl = {o_bcd[4*NDIG-5:0], acc_code};
    end else begin : g_single
        assign bcd_shl = acc_code;
    end

    // FSM state, debounce counter and latched code registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            deb_cnt <= '0;
            code    <= 4'd0;
`ifdef HOLD_REPEAT_EN
            rpt_cnt <= '0;
            i_prev  <= 4'd0;
`endif
        end else begin
            state   <= state_nxt;
            deb_cnt <= deb_nxt;
            code    <= code_nxt;
`ifdef HOLD_REPEAT_EN
            rpt_cnt <= rpt_nxt;
            i_prev  <= i;
`endif
        end
    end

    // Next-state logic; accept is asserted on the DEB_CYC-th matching sample.
    always_comb begin
        state_nxt = state;
        deb_nxt   = deb_cnt;
        code_nxt  = code;
        acc_code  = code;
        accept    = 1'b0;
        illegal   = 1'b0;
`ifdef HOLD_REPEAT_EN
        rpt_nxt   = '0;
`endif
        case (state)
            IDLE: begin
                deb_nxt = '0;
                if (i >= 4'd10) begin
                    illegal = 1'b1;
                end else if (i != 4'd0) begin
                    code_nxt = i;
                    if (DEB_CYC <= 1) begin
                        accept    = 1'b1;
                        acc_code  = i;
                        state_nxt = HELD;
                    end else begin
                        deb_nxt   = DW'(1);
                        state_nxt = DEB;
                    end
                end
            end
            DEB: begin
                if (i == code) begin
                    if (deb_cnt >= DW'(DEB_CYC-1)) begin
                        accept    = 1'b1;
                        deb_nxt   = '0;
                        state_nxt = HELD;
                    end else begin
                        deb_nxt = deb_cnt + DW'(1);
                    end
                end else begin
                    deb_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            HELD: begin
                if (i == 4'd0) begin
                    state_nxt = IDLE;
                end
`ifdef HOLD_REPEAT_EN
                else if (i != i_prev) begin
                    rpt_nxt = '0;
                end else if (rpt_cnt >= RW'(RPT_CYC-1)) begin
                    accept  = 1'b1;
                    rpt_nxt = '0;
                end else begin
                    rpt_nxt = rpt_cnt + RW'(1);
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Entry register, count, strobe and sticky error; priority clr > accept > bksp.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_bcd  <= '0;
            o_cnt  <= '0;
            o_stb  <= 1'b0;
            o_err  <= 1'b0;
            bksp_q <= 1'b0;
        end else begin
            bksp_q <= bksp;
            o_stb  <= accept;
            if (clr) begin
                o_bcd <= '0;
                o_cnt <= '0;
                o_err <= 1'b0;
            end else begin
                if (illegal || (accept && o_full)) begin
                    o_err <= 1'b1;
                end
                if (accept) begin
                    if (!o_full) begin
                        o_bcd <= bcd_shl;
                        o_cnt <= o_cnt + CW'(1);
                    end
                end else if (bksp_edge && (o_cnt != '0)) begin
                    o_bcd <= o_bcd >> 4;
                    o_cnt <= o_cnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_digit_accum.sv
// Directed self-checking bench for keypad_digit_accum (NDIG=4, DEB_CYC=4, RPT_CYC=50).
module tb_keypad_digit_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  i;
    logic        clr;
    logic        bksp;
    logic [15:0] o_bcd;
    logic [2:0]  o_cnt;
    logic        o_full;
    logic        o_stb;
    logic        o_err;

    int n_checks = 0;
    int n_fail   = 0;
    int stb_count = 0;

    keypad_digit_accum #(.NDIG(4), .DEB_CYC(4), .RPT_CYC(50)) dut (
        .clk(clk), .rst(rst), .i(i), .clr(clr), .bksp(bksp),
        .o_bcd(o_bcd), .o_cnt(o_cnt), .o_full(o_full), .o_stb(o_stb), .o_err(o_err)
    );

    always #5 clk = ~clk;

    // Strobe pulses counted on the falling edge, away from the update edge.
    always @(negedge clk) if (o_stb === 1'b1) stb_count <= stb_count + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        i = d; tick(6);
        i = 4'd0; tick(2);
    endtask

    task automatic do_clr();
        clr = 1'b1; tick(1);
        clr = 1'b0; tick(1);
    endtask

    task automatic test_reset();
        rst = 1'b1; i = 4'd5; clr = 1'b0; bksp = 1'b0;
        tick(2);
        n_checks++;
        if ({o_bcd, o_cnt, o_full, o_stb, o_err} !== 23'd0) begin
            n_fail++; $display("FAIL reset_outputs: got bcd=%h cnt=%0d full=%b stb=%b err=%b, want all 0",
                               o_bcd, o_cnt, o_full, o_stb, o_err);
        end
        rst = 1'b0;
        tick(3);
        n_checks++;
        if (o_stb !== 1'b0) begin n_fail++; $display("FAIL early_stb: got %b want 0", o_stb); end
        tick(1);
        n_checks++;
        if (o_stb !== 1'b1 || o_bcd !== 16'h0005 || o_cnt !== 3'd1) begin
            n_fail++; $display("FAIL first_accept: got stb=%b bcd=%h cnt=%0d want 1/0005/1", o_stb, o_bcd, o_cnt);
        end
        i = 4'd0; tick(2);
        // reset in the middle of debounce restarts it from scratch
        i = 4'd4; tick(2);
        rst = 1'b1; tick(1);
        rst = 1'b0; tick(3);
        n_checks++;
        if (o_stb !== 1'b0 || o_cnt !== 3'd0) begin
            n_fail++; $display("FAIL rst_mid_deb: got stb=%b cnt=%0d want 0/0", o_stb, o_cnt);
        end
        tick(1);
        n_checks++;
        if (o_stb !== 1'b1 || o_bcd !== 16'h0004) begin
            n_fail++; $display("FAIL rst_redebounce: got stb=%b bcd=%h want 1/0004", o_stb, o_bcd);
        end
        i = 4'd0; tick(2);
        do_clr();
    endtask

    task automatic test_two_keys();
        int s0;
        s0 = stb_count;
        i = 4'd3; tick(10);
        i = 4'd0; tick(2);
        i = 4'd7; tick(10);
        i = 4'd0; tick(2);
        n_checks++;
        if (stb_count - s0 !== 2 || o_bcd !== 16'h0037 || o_cnt !== 3'd2) begin
            n_fail++; $display("FAIL two_keys: got pulses=%0d bcd=%h cnt=%0d want 2/0037/2",
                               stb_count - s0, o_bcd, o_cnt);
        end
        do_clr();
    endtask

    task automatic test_bounce();
        int s0;
        s0 = stb_count;
        i = 4'd3; tick(2);
        i = 4'd0; tick(1);
        i = 4'd3; tick(2);
        i = 4'd0; tick(3);
        n_checks++;
        if (stb_count - s0 !== 0 || o_cnt !== 3'd0) begin
            n_fail++; $display("FAIL bounce: got pulses=%0d cnt=%0d want 0/0", stb_count - s0, o_cnt);
        end
    endtask

    task automatic test_full();
        int s0;
        s0 = stb_count;
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        n_checks++;
        if (o_bcd !== 16'h1234 || o_full !== 1'b1 || o_err !== 1'b0) begin
            n_fail++; $display("FAIL fill: got bcd=%h full=%b err=%b want 1234/1/0", o_bcd, o_full, o_err);
        end
        press(4'd9);
        n_checks++;
        if (o_bcd !== 16'h1234 || o_cnt !== 3'd4 || o_err !== 1'b1 || stb_count - s0 !== 5) begin
            n_fail++; $display("FAIL overflow: got bcd=%h cnt=%0d err=%b pulses=%0d want 1234/4/1/5",
                               o_bcd, o_cnt, o_err, stb_count - s0);
        end
        clr = 1'b1; tick(1); clr = 1'b0;
        n_checks++;
        if (o_bcd !== 16'h0 || o_cnt !== 3'd0 || o_err !== 1'b0 || o_full !== 1'b0) begin
            n_fail++; $display("FAIL clear: got bcd=%h cnt=%0d err=%b full=%b want 0/0/0/0", o_bcd, o_cnt, o_err, o_full);
        end
        tick(1);
    endtask

    task automatic test_bksp();
        press(4'd1); press(4'd2); press(4'd3);
        bksp = 1'b1; tick(5);
        bksp = 1'b0; tick(1);
        n_checks++;
        if (o_bcd !== 16'h0012 || o_cnt !== 3'd2) begin
            n_fail++; $display("FAIL bksp_held: got bcd=%h cnt=%0d want 0012/2", o_bcd, o_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            bksp = 1'b1; tick(1);
            bksp = 1'b0; tick(1);
        end
        n_checks++;
        if (o_bcd !== 16'h0 || o_cnt !== 3'd0 || o_err !== 1'b0) begin
            n_fail++; $display("FAIL bksp_empty: got bcd=%h cnt=%0d err=%b want 0/0/0", o_bcd, o_cnt, o_err);
        end
    endtask

    task automatic test_illegal();
        int s0;
        s0 = stb_count;
        i = 4'd12; tick(3);
        i = 4'd0; tick(1);
        n_checks++;
        if (o_err !== 1'b1 || stb_count - s0 !== 0 || o_cnt !== 3'd0) begin
            n_fail++; $display("FAIL illegal: got err=%b pulses=%0d cnt=%0d want 1/0/0", o_err, stb_count - s0, o_cnt);
        end
        do_clr();
    endtask

    task automatic test_priority();
        press(4'd2);
        // clr lands on the accepting edge
        i = 4'd6; tick(3);
        clr = 1'b1; tick(1); clr = 1'b0;
        n_checks++;
        if (o_stb !== 1'b1 || o_bcd !== 16'h0 || o_cnt !== 3'd0) begin
            n_fail++; $display("FAIL clr_vs_accept: got stb=%b bcd=%h cnt=%0d want 1/0000/0", o_stb, o_bcd, o_cnt);
        end
        i = 4'd0; tick(2);
        press(4'd5);
        // bksp edge lands on the accepting edge and must be dropped
        i = 4'd7; tick(3);
        bksp = 1'b1; tick(1);
        tick(1);
        bksp = 1'b0;
        n_checks++;
        if (o_bcd !== 16'h0057 || o_cnt !== 3'd2) begin
            n_fail++; $display("FAIL accept_vs_bksp: got bcd=%h cnt=%0d want 0057/2", o_bcd, o_cnt);
        end
        i = 4'd0; tick(2);
        do_clr();
    endtask

    task automatic test_hold_long();
        int s0;
        int want;
        s0 = stb_count;
`ifdef HOLD_REPEAT_EN
        want = 3;
`else
        want = 1;
`endif
        i = 4'd8; tick(120);
        i = 4'd0; tick(2);
        n_checks++;
        if (stb_count - s0 !== want) begin
            n_fail++; $display("FAIL hold_long: got pulses=%0d want %0d", stb_count - s0, want);
        end
        do_clr();
    endtask

    initial begin
        test_reset();
        test_two_keys();
        test_bounce();
        test_full();
        test_bksp();
        test_illegal();
        test_priority();
        test_hold_long();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
